// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with per-register ROB rename status and commit bypass
module reg_status_file #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int Q_WIDTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      has_issue,
  input  logic                      issue_modify_regfile,
  input  logic [REG_ADDR_WIDTH-1:0] issue_reg_addr,
  input  logic [Q_WIDTH-1:0]        issue_rob_pos,
  input  logic                      has_commit,
  input  logic                      commit_modify_regfile,
  input  logic [REG_ADDR_WIDTH-1:0] commit_reg_addr,
  input  logic [Q_WIDTH-1:0]        Commit_Q,
  input  logic [31:0]               Commit_V,
  input  logic                      flush_in,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [Q_WIDTH-1:0]        rs1_Q,
  output logic [Q_WIDTH-1:0]        rs2_Q,
  output logic [31:0]               rs1_V,
  output logic [31:0]               rs2_V
);
  localparam int N = 2 ** REG_ADDR_WIDTH;
  logic [31:0]        v [N];
  logic [Q_WIDTH-1:0] q [N];
  logic [N-1:0]       busy;
  logic cm, iw, clr, hit1, hit2;
  always_comb begin
    cm   = has_commit && commit_modify_regfile && commit_reg_addr != '0;
    iw   = has_issue && issue_modify_regfile && issue_reg_addr != '0 && !flush_in;
    clr  = cm && busy[commit_reg_addr] && q[commit_reg_addr] == Commit_Q;
    hit1 = clr && rs1_addr == commit_reg_addr;
    hit2 = clr && rs2_addr == commit_reg_addr;
    rs1_busy = rs1_addr != '0 && busy[rs1_addr] && !hit1;
    rs2_busy = rs2_addr != '0 && busy[rs2_addr] && !hit2;
    rs1_Q = rs1_busy ? q[rs1_addr] : '0;
    rs2_Q = rs2_busy ? q[rs2_addr] : '0;
    rs1_V = hit1 ? Commit_V : rs1_addr == '0 ? 32'h0 : v[rs1_addr];
    rs2_V = hit2 ? Commit_V : rs2_addr == '0 ? 32'h0 : v[rs2_addr];
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy <= '0;
      for (int i = 0; i < N; i++) begin
        v[i] <= '0;
        q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (cm) v[commit_reg_addr] <= Commit_V;
      if (flush_in) begin
        busy <= '0;
        for (int i = 0; i < N; i++) q[i] <= '0;
      end else begin
        if (clr) begin
          busy[commit_reg_addr] <= 1'b0;
          q[commit_reg_addr]    <= '0;
        end
        if (iw) begin
          busy[issue_reg_addr] <= 1'b1;
          q[issue_reg_addr]    <= issue_rob_pos;
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: randomized and directed checks of reg_status_file against a register-array model
module tb_reg_status_file;
  logic clk_in = 0, rst_n_in = 0, rdy_in = 1;
  logic has_issue, issue_modify_regfile, has_commit, commit_modify_regfile, flush_in;
  logic [4:0] issue_reg_addr, commit_reg_addr, rs1_addr, rs2_addr;
  logic [3:0] issue_rob_pos, Commit_Q, rs1_Q, rs2_Q;
  logic [31:0] Commit_V, rs1_V, rs2_V;
  logic rs1_busy, rs2_busy;
  int errors = 0, checks = 0;
  logic [31:0] mv [32];
  logic [3:0]  mq [32];
  bit          mb [32];

  reg_status_file dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .has_issue(has_issue), .issue_modify_regfile(issue_modify_regfile),
    .issue_reg_addr(issue_reg_addr), .issue_rob_pos(issue_rob_pos),
    .has_commit(has_commit), .commit_modify_regfile(commit_modify_regfile),
    .commit_reg_addr(commit_reg_addr), .Commit_Q(Commit_Q), .Commit_V(Commit_V),
    .flush_in(flush_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_Q(rs1_Q), .rs2_Q(rs2_Q),
    .rs1_V(rs1_V), .rs2_V(rs2_V)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 0;
      mq[i] = 0;
      mb[i] = 0;
    end
  endtask

  function automatic void ref_look(input logic [4:0] a, output logic b, output logic [3:0] q, output logic [31:0] v);
    b = 0;
    q = 0;
    v = 0;
    if (a != 0) begin
      if (has_commit && commit_modify_regfile && a == commit_reg_addr && mb[a] && mq[a] == Commit_Q)
        v = Commit_V;
      else begin
        b = mb[a];
        q = mb[a] ? mq[a] : 4'd0;
        v = mv[a];
      end
    end
  endfunction

  task automatic idle();
    rdy_in = 1;
    has_issue = 0;
    issue_modify_regfile = 0;
    issue_reg_addr = 0;
    issue_rob_pos = 0;
    has_commit = 0;
    commit_modify_regfile = 0;
    commit_reg_addr = 0;
    Commit_Q = 0;
    Commit_V = 0;
    flush_in = 0;
  endtask

  task automatic look();
    logic b;
    logic [3:0] q;
    logic [31:0] v;
    #2;
    ref_look(rs1_addr, b, q, v);
    chk("rs1_busy", rs1_busy, b);
    chk("rs1_Q", rs1_Q, q);
    chk("rs1_V", rs1_V, v);
    ref_look(rs2_addr, b, q, v);
    chk("rs2_busy", rs2_busy, b);
    chk("rs2_Q", rs2_Q, q);
    chk("rs2_V", rs2_V, v);
  endtask

  task automatic tick();
    bit cw;
    @(posedge clk_in);
    if (rdy_in) begin
      cw = has_commit && commit_modify_regfile && commit_reg_addr != 0;
      if (cw) mv[commit_reg_addr] = Commit_V;
      if (flush_in) begin
        for (int i = 0; i < 32; i++) begin
          mb[i] = 0;
          mq[i] = 0;
        end
      end else begin
        if (cw && mb[commit_reg_addr] && mq[commit_reg_addr] == Commit_Q) begin
          mb[commit_reg_addr] = 0;
          mq[commit_reg_addr] = 0;
        end
        if (has_issue && issue_modify_regfile && issue_reg_addr != 0) begin
          mb[issue_reg_addr] = 1;
          mq[issue_reg_addr] = issue_rob_pos;
        end
      end
    end
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [3:0] t);
    has_issue = 1;
    issue_modify_regfile = 1;
    issue_reg_addr = a;
    issue_rob_pos = t;
  endtask

  task automatic commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    has_commit = 1;
    commit_modify_regfile = 1;
    commit_reg_addr = a;
    Commit_Q = t;
    Commit_V = d;
  endtask

  initial begin
    idle();
    model_reset();
    rs1_addr = 5;
    rs2_addr = 0;
    #3;
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_rs1_Q", rs1_Q, 0);
    chk("rst_rs1_V", rs1_V, 0);
    chk("rst_rs2_busy", rs2_busy, 0);
    chk("rst_rs2_V", rs2_V, 0);
    #9 rst_n_in = 1;
    @(posedge clk_in);
    #1;
    look();
    issue(3, 2);
    rs1_addr = 3;
    look();
    chk("t2_same_cycle_issue_hidden", rs1_busy, 0);
    tick();
    idle();
    look();
    chk("t2_busy", rs1_busy, 1);
    chk("t2_Q", rs1_Q, 2);
    commit(3, 2, 32'hDEADBEEF);
    look();
    chk("t2_bypass_busy", rs1_busy, 0);
    chk("t2_bypass_V", rs1_V, 32'hDEADBEEF);
    tick();
    idle();
    look();
    chk("t2_after_busy", rs1_busy, 0);
    chk("t2_after_V", rs1_V, 32'hDEADBEEF);
    issue(4, 1);
    tick();
    issue(4, 3);
    tick();
    idle();
    commit(4, 1, 7);
    rs1_addr = 4;
    look();
    chk("t3_no_bypass_busy", rs1_busy, 1);
    chk("t3_no_bypass_Q", rs1_Q, 3);
    tick();
    idle();
    look();
    chk("t3_busy", rs1_busy, 1);
    chk("t3_Q", rs1_Q, 3);
    chk("t3_V", rs1_V, 7);
    issue(6, 5);
    tick();
    idle();
    commit(6, 5, 9);
    issue(6, 8);
    tick();
    idle();
    rs1_addr = 6;
    look();
    chk("t4_busy", rs1_busy, 1);
    chk("t4_Q", rs1_Q, 8);
    chk("t4_V", rs1_V, 9);
    issue(1, 1);
    tick();
    issue(2, 2);
    tick();
    issue(7, 3);
    tick();
    idle();
    flush_in = 1;
    issue(9, 4);
    commit(2, 9, 32'h11);
    tick();
    idle();
    for (int r = 0; r < 32; r++) begin
      rs1_addr = r[4:0];
      #1;
      chk("t5_flush_busy", rs1_busy, 0);
    end
    rs1_addr = 2;
    rs2_addr = 9;
    look();
    chk("t5_V2", rs1_V, 32'h11);
    chk("t5_x9_busy", rs2_busy, 0);
    issue(0, 4);
    commit(0, 0, 32'h55);
    rs1_addr = 0;
    tick();
    idle();
    look();
    chk("t6_x0_busy", rs1_busy, 0);
    chk("t6_x0_V", rs1_V, 0);
    issue(5, 4);
    tick();
    idle();
    rdy_in = 0;
    commit(5, 4, 32'h1234);
    issue(8, 6);
    flush_in = 1;
    tick();
    idle();
    rs1_addr = 5;
    rs2_addr = 8;
    look();
    chk("t6_hold_busy", rs1_busy, 1);
    chk("t6_hold_Q", rs1_Q, 4);
    chk("t6_hold_V", rs1_V, 0);
    chk("t6_hold_x8", rs2_busy, 0);
    rs1_addr = 3;
    #1 rst_n_in = 0;
    #1;
    model_reset();
    chk("t6_async_V", rs1_V, 0);
    rs1_addr = 5;
    #1;
    chk("t6_async_busy", rs1_busy, 0);
    rst_n_in = 1;
    @(posedge clk_in);
    #1;
    look();
    for (int n = 0; n < 2000; n++) begin
      rdy_in = $urandom_range(0, 9) != 0;
      has_issue = $urandom_range(0, 2) != 0;
      issue_modify_regfile = $urandom_range(0, 4) != 0;
      issue_reg_addr = 5'($urandom_range(0, 7));
      issue_rob_pos = 4'($urandom_range(1, 15));
      has_commit = $urandom_range(0, 1);
      commit_modify_regfile = $urandom_range(0, 4) != 0;
      commit_reg_addr = 5'($urandom_range(0, 7));
      Commit_Q = $urandom_range(0, 1) ? mq[commit_reg_addr] : 4'($urandom_range(1, 15));
      Commit_V = $urandom;
      flush_in = $urandom_range(0, 19) == 0;
      rs1_addr = $urandom_range(0, 3) == 0 ? commit_reg_addr : 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      look();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
